// File: rtl/btn_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_mode_ctrl
// Purpose  : Button-driven waveform select and frequency index; optional
//            hold-to-repeat on the frequency buttons via BTN_AUTO_REPEAT_EN.
// Revision : 1.0
// ============================================================================
module btn_mode_ctrl #(
  parameter int HOLD_CYC   = 25000000,
  parameter int REPEAT_CYC = 5000000
) (
  input  logic       Fg_CLK,
  input  logic       RESETn,
  input  logic       iWaveBtn,
  input  logic       iUpBtn,
  input  logic       iDnBtn,
  output logic [1:0] oWaveSel,
  output logic [3:0] oFreqIdx,
  output logic       oUpdate
);

  localparam int         c_cntMax  = 33554431;
  localparam logic [3:0] c_freqTop = 4'd15;

  if (HOLD_CYC < 2 || HOLD_CYC > c_cntMax ||
      REPEAT_CYC < 2 || REPEAT_CYC > c_cntMax) begin : g_badParam
    $error("btn_mode_ctrl: HOLD_CYC/REPEAT_CYC outside 2..2^25-1");
  end

  // A button held through reset must be seen released before it can press.
  logic r_waveQ, r_upQ, r_dnQ;
  logic r_waveArm, r_upArm, r_dnArm;
  logic w_wavePress, w_upPress, w_dnPress;

  assign w_wavePress = iWaveBtn & ~r_waveQ & r_waveArm;
  assign w_upPress   = iUpBtn   & ~r_upQ   & r_upArm;
  assign w_dnPress   = iDnBtn   & ~r_dnQ   & r_dnArm;

  logic w_step;
  logic w_stepUp;

`ifdef BTN_AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam logic [24:0] c_holdLast   = 25'(HOLD_CYC - 1);
  localparam logic [24:0] c_repeatLast = 25'(REPEAT_CYC - 1);

  state_t      r_state, w_stateNxt;
  logic [24:0] r_cnt, w_cntNxt;
  logic        r_dirUp, w_dirUpNxt;
  logic        w_held;

  assign w_held = r_dirUp ? (iUpBtn & ~iDnBtn) : (iDnBtn & ~iUpBtn);

  always_comb begin
    w_stateNxt = r_state;
    w_cntNxt   = '0;
    w_dirUpNxt = r_dirUp;
    w_step     = 1'b0;
    w_stepUp   = r_dirUp;
    case (r_state)
      S_IDLE: begin
        if (w_upPress && !iDnBtn) begin
          w_step     = 1'b1;
          w_stepUp   = 1'b1;
          w_dirUpNxt = 1'b1;
          w_stateNxt = S_HOLD;
        end else if (w_dnPress && !iUpBtn) begin
          w_step     = 1'b1;
          w_stepUp   = 1'b0;
          w_dirUpNxt = 1'b0;
          w_stateNxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_held) begin
          w_stateNxt = S_IDLE;
        end else if (r_cnt == c_holdLast) begin
          w_step     = 1'b1;
          w_stateNxt = S_REPEAT;
        end else begin
          w_cntNxt = r_cnt + 25'd1;
        end
      end
      S_REPEAT: begin
        if (!w_held) begin
          w_stateNxt = S_IDLE;
        end else if (r_cnt == c_repeatLast) begin
          w_step = 1'b1;
        end else begin
          w_cntNxt = r_cnt + 25'd1;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end
`else
  always_comb begin
    w_step   = 1'b0;
    w_stepUp = 1'b0;
    if (w_upPress && !iDnBtn) begin
      w_step   = 1'b1;
      w_stepUp = 1'b1;
    end else if (w_dnPress && !iUpBtn) begin
      w_step = 1'b1;
    end
  end
`endif

  // Saturated steps leave the index untouched, so they raise no update.
  logic [3:0] w_freqNxt;
  logic [1:0] w_waveNxt;
  logic       w_change;

  always_comb begin
    w_freqNxt = oFreqIdx;
    if (w_step) begin
      if (w_stepUp && oFreqIdx != c_freqTop) begin
        w_freqNxt = oFreqIdx + 4'd1;
      end else if (!w_stepUp && oFreqIdx != 4'd0) begin
        w_freqNxt = oFreqIdx - 4'd1;
      end
    end
  end

  assign w_waveNxt = w_wavePress ? oWaveSel + 2'd1 : oWaveSel;
  assign w_change  = w_wavePress | (w_freqNxt != oFreqIdx);

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_waveQ   <= 1'b0;
      r_upQ     <= 1'b0;
      r_dnQ     <= 1'b0;
      r_waveArm <= 1'b0;
      r_upArm   <= 1'b0;
      r_dnArm   <= 1'b0;
      oWaveSel  <= 2'd0;
      oFreqIdx  <= 4'd0;
      oUpdate   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dirUp   <= 1'b0;
`endif
    end else begin
      r_waveQ   <= iWaveBtn;
      r_upQ     <= iUpBtn;
      r_dnQ     <= iDnBtn;
      r_waveArm <= r_waveArm | ~iWaveBtn;
      r_upArm   <= r_upArm   | ~iUpBtn;
      r_dnArm   <= r_dnArm   | ~iDnBtn;
      oWaveSel  <= w_waveNxt;
      oFreqIdx  <= w_freqNxt;
      oUpdate   <= w_change;
`ifdef BTN_AUTO_REPEAT_EN
      r_state   <= w_stateNxt;
      r_cnt     <= w_cntNxt;
      r_dirUp   <= w_dirUpNxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_mode_ctrl.sv
`default_nettype none
// Bench for btn_mode_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a run-length model of press/hold/repeat.
module tb_btn_mode_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic       clk  = 1'b0;
  logic       rstN = 1'b1;
  logic       wv   = 1'b0;
  logic       up   = 1'b0;
  logic       dn   = 1'b0;
  logic [1:0] waveSel;
  logic [3:0] freqIdx;
  logic       upd;

  btn_mode_ctrl #(
    .HOLD_CYC  (HOLD),
    .REPEAT_CYC(REP)
  ) dut (
    .Fg_CLK  (clk),
    .RESETn  (rstN),
    .iWaveBtn(wv),
    .iUpBtn  (up),
    .iDnBtn  (dn),
    .oWaveSel(waveSel),
    .oFreqIdx(freqIdx),
    .oUpdate (upd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: outputs, per-button history, and the current held run.
  int       mWave, mFreq, mN;
  bit       mUpd, mRun, mDirUp;
  bit [2:0] mPrev, mArm;

  int          updCount;
  logic [20:0] updSeen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mWave = 0; mFreq = 0; mUpd = 1'b0; mN = 0;
    mRun = 1'b0; mDirUp = 1'b0; mPrev = 3'b000; mArm = 3'b000;
  endtask

  // One sampling edge: steps fall at run lengths 0, HOLD, HOLD+k*REP.
  task automatic modelEdge();
    bit [2:0] cur, press;
    int step, nf;
    cur   = {dn, up, wv};
    press = cur & ~mPrev & mArm;
    step  = 0;
    if (mRun) begin
      if (mDirUp ? (up && !dn) : (dn && !up)) begin
        mN++;
        if (mN == HOLD || (mN > HOLD && (mN - HOLD) % REP == 0))
          step = mDirUp ? 1 : -1;
      end else begin
        mRun = 1'b0;
      end
    end else if (press[1] && !dn) begin
      step = 1; mDirUp = 1'b1; mN = 0;
`ifdef BTN_AUTO_REPEAT_EN
      mRun = 1'b1;
`endif
    end else if (press[2] && !up) begin
      step = -1; mDirUp = 1'b0; mN = 0;
`ifdef BTN_AUTO_REPEAT_EN
      mRun = 1'b1;
`endif
    end
    nf = mFreq + step;
    if (nf > 15) nf = 15;
    if (nf < 0) nf = 0;
    mUpd  = (nf != mFreq) || press[0];
    mFreq = nf;
    if (press[0]) mWave = (mWave + 1) % 4;
    mArm  = mArm | ~cur;
    mPrev = cur;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstN) modelEdge();
    #1;
    chk("waveSel", 32'(waveSel), 32'(mWave));
    chk("freqIdx", 32'(freqIdx), 32'(mFreq));
    chk("update",  32'(upd),     32'(mUpd));
  endtask

  task automatic applyReset();
    #2 rstN = 1'b0;
    #1 modelReset();
    chk("rstWave",   32'(waveSel), 32'd0);
    chk("rstFreq",   32'(freqIdx), 32'd0);
    chk("rstUpdate", 32'(upd),     32'd0);
    repeat (2) tick();
    @(negedge clk) rstN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    applyReset();
    repeat (2) tick();

    // Four waveform presses walk the select around 1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      wv = 1'b1; tick();
      chk("wavePress", 32'(waveSel), 32'((k + 1) % 4));
      chk("wavePulse", 32'(upd), 32'd1);
      wv = 1'b0; tick();
    end

    // Up held 20 cycles from index 0.
    up = 1'b1;
    updSeen = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      updSeen[c] = upd;
    end
    up = 1'b0; tick();
`ifdef BTN_AUTO_REPEAT_EN
    chk("hold20Freq",  32'(freqIdx), 32'd4);
    chk("hold20Steps", 32'(updSeen), 32'h22202);
`else
    chk("hold20Freq",  32'(freqIdx), 32'd1);
    chk("hold20Steps", 32'(updSeen), 32'h00002);
`endif

    // Saturation at the top and bottom of the range.
    repeat (16) begin up = 1'b1; tick(); up = 1'b0; tick(); end
    up = 1'b1; tick();
    chk("satTopFreq", 32'(freqIdx), 32'd15);
    chk("satTopUpd",  32'(upd), 32'd0);
    up = 1'b0; tick();
    repeat (16) begin dn = 1'b1; tick(); dn = 1'b0; tick(); end
    dn = 1'b1; tick();
    chk("satBotFreq", 32'(freqIdx), 32'd0);
    chk("satBotUpd",  32'(upd), 32'd0);
    dn = 1'b0; tick();

    // Both buttons rising together, then down asserted during an up HOLD.
    up = 1'b1; tick(); up = 1'b0; tick();
    up = 1'b1; dn = 1'b1;
    updCount = 0;
    repeat (12) begin tick(); updCount += 32'(upd); end
    chk("bothFreq", 32'(freqIdx), 32'd1);
    chk("bothUpd",  32'(updCount), 32'd0);
    up = 1'b0; dn = 1'b0; tick();
    up = 1'b1; repeat (4) tick();
    dn = 1'b1;
    updCount = 0;
    repeat (12) begin tick(); updCount += 32'(upd); end
    chk("abortFreq", 32'(freqIdx), 32'd2);
    chk("abortUpd",  32'(updCount), 32'd0);
    up = 1'b0; dn = 1'b0; tick();

    // Reset during REPEAT with up still held.
    up = 1'b1; repeat (14) tick();
    applyReset();
    updCount = 0;
    repeat (20) begin tick(); updCount += 32'(upd); end
    chk("heldRstFreq", 32'(freqIdx), 32'd0);
    chk("heldRstUpd",  32'(updCount), 32'd0);
    up = 1'b0; tick();
    up = 1'b1; tick();
    chk("repressFreq", 32'(freqIdx), 32'd1);
    chk("repressUpd",  32'(upd), 32'd1);
    up = 1'b0; tick();

    // Random button traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) applyReset();
      if ($urandom_range(0, 9) < 3) wv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 2) up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 2) dn = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
